// File: rtl/repeat_count_ctrl_pkg.sv
// Shared constants for the signed calculator's iteration control.
// The multiply/divide datapath control uses the same state encoding.
package repeat_count_ctrl_pkg;

    localparam int CALC_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/repeat_count_ctrl_if.sv
// Start/step handshake and status bundle between the calculator sequencer and
// the repeat-count controller.
interface repeat_count_ctrl_if #(
    parameter int WIDTH = repeat_count_ctrl_pkg::CALC_W
);

    logic             start;
    logic [WIDTH-1:0] count_in;
    logic             sign_in;
    logic             step_ack;
    logic             step_valid;
    logic [WIDTH-1:0] count_q;
    logic             sign_q;
    logic             busy;
    logic             done;

    modport master (
        output start, count_in, sign_in, step_ack,
        input  step_valid, count_q, sign_q, busy, done
    );

    modport slave (
        input  start, count_in, sign_in, step_ack,
        output step_valid, count_q, sign_q, busy, done
    );

endinterface

// File: rtl/repeat_count_ctrl_count_dec_stage.sv
// Decrement-by-one stage built from a half-subtractor borrow chain.
// With en low the input passes through unchanged.
module count_dec_stage
    import repeat_count_ctrl_pkg::*;
#(
    parameter int WIDTH = CALC_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] diff;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_hsub
        assign diff[i] = a[i] ^ borrow[i];
        if (i < WIDTH - 1) begin : g_borrow
            assign borrow[i+1] = ~a[i] & borrow[i];
        end
    end

    assign y = en ? diff : a;

endmodule

// File: rtl/repeat_count_ctrl.sv
// Iteration controller for repeated-add multiply / repeated-subtract divide:
// loads a magnitude count, issues one step per iteration and pulses done at zero.
module repeat_count_ctrl
    import repeat_count_ctrl_pkg::*;
#(
    parameter int WIDTH = CALC_W
) (
    input  logic                clk,
    input  logic                rst,
    repeat_count_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             fire;
    logic [WIDTH-1:0] dec_out;

    assign fire = (state_q == ST_RUN) && bus.step_ack;

    count_dec_stage #(.WIDTH(WIDTH)) u_dec (
        .a  (cnt_q),
        .en (fire),
        .y  (dec_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.count_in;
                    sgn_d   = bus.sign_in;
                    state_d = (bus.count_in != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    cnt_d = dec_out;
                    // Leaving at 1 means the register can never be decremented from 0.
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
        end
    end

    assign bus.step_valid = (state_q == ST_RUN);
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_FIN);
    assign bus.count_q    = cnt_q;
    assign bus.sign_q     = sgn_q;

endmodule

// File: tb/tb_repeat_count_ctrl.sv
// Scoreboard bench for repeat_count_ctrl: each accepted start queues the
// expected step/done events, a negedge monitor pops and compares them.
module tb_repeat_count_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    repeat_count_ctrl_if bus ();

    repeat_count_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit is_done;
        int cnt;
        bit sgn;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // An accepted start of n iterations yields n steps seen with counts n..1, then one done.
    task automatic push_seq(input int n, input bit s);
        ev_t e;
        for (int k = n; k >= 1; k--) begin
            e.is_done = 1'b0; e.cnt = k; e.sgn = s;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1; e.cnt = 0; e.sgn = s;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_order", int'(e.is_done), 1);
                    chk("done_count", int'(bus.count_q), 0);
                    chk("done_sign", int'(bus.sign_q), int'(e.sgn));
                    chk("done_no_valid", int'(bus.step_valid), 0);
                end
            end else if (bus.step_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("step_kind", int'(e.is_done), 0);
                    chk("step_count", int'(bus.count_q), e.cnt);
                    chk("step_sign", int'(bus.sign_q), int'(e.sgn));
                    chk("step_busy", int'(bus.busy), 1);
                    if (bus.step_ack) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_idle(input string tag, input int sgn);
        chk({tag, "_count"}, int'(bus.count_q), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_valid"}, int'(bus.step_valid), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_sign"}, int'(bus.sign_q), sgn);
    endtask

    // Runs one sequence starting from IDLE; returns in the IDLE cycle after FIN.
    task automatic run_seq(input int n, input bit s, input int ack_pct,
                           input int stall, input bit collide);
        int cyc;
        int exp_cyc;
        bit fin;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.count_in = 6'(n);
        bus.sign_in  = s;
        bus.step_ack = (stall > 0) ? 1'b0 : 1'($urandom_range(1));
        push_seq(n, s);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        fin = 1'b0;
        exp_cyc = (n == 0) ? 1 : stall + n + 1;
        while (!fin && cyc < 2000) begin
            if (bus.done) begin
                fin = 1'b1;
                if (ack_pct >= 100) chk("done_latency", cyc, exp_cyc);
            end
            bus.step_ack = (cyc <= stall) ? 1'b0 : ($urandom_range(99) < ack_pct);
            if (collide && $urandom_range(2) == 0) begin
                bus.start    = 1'b1;
                bus.count_in = 6'($urandom_range(63));
                bus.sign_in  = 1'($urandom_range(1));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start    = 1'b0;
        bus.step_ack = 1'b0;
        if (!fin) chk("done_timeout", 0, 1);
        check_idle("post_seq", int'(s));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.count_in = '0;
        bus.sign_in  = 1'b0;
        bus.step_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 0);
        rst = 1'b0;

        // Reset asserted mid-RUN with count_q held at 5.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.count_in = 6'd5; bus.sign_in = 1'b1; bus.step_ack = 1'b0;
        push_seq(5, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_count", int'(bus.count_q), 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_idle("midrun_rst1", 0);
        @(posedge clk); #1;
        check_idle("midrun_rst2", 0);
        rst = 1'b0;

        run_seq(3, 1'b1, 100, 0, 1'b0);
        run_seq(2, 1'b0, 100, 4, 1'b0);
        run_seq(0, 1'b1, 100, 0, 1'b0);
        run_seq(63, 1'b0, 100, 0, 1'b0);
        run_seq(5, 1'b1, 100, 0, 1'b1);
        run_seq(1, 1'b0, 100, 0, 1'b1);
        run_seq(0, 1'b0, 100, 0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            run_seq(($urandom_range(3) == 0) ? $urandom_range(63) : $urandom_range(6),
                    1'($urandom_range(1)),
                    ($urandom_range(1) == 0) ? 100 : $urandom_range(30, 90),
                    $urandom_range(3), 1'($urandom_range(1)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
